// File: rtl/bitstream_output_buffer.sv
// Byte FIFO that accepts up to four carry-resolved bitstream bytes per cycle and
// streams them out one per cycle with a per-byte end-of-frame tag.
module bitstream_output_buffer #(
    parameter int unsigned OB_BITSTREAM_WIDTH = 8,
    parameter int unsigned OB_ADDR_WIDTH      = 4
) (
    input  logic                          ob_clk,
    input  logic                          ob_reset,
    input  logic [2:0]                    in_flag_bitstream,
    input  logic [OB_BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [OB_BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic [OB_BITSTREAM_WIDTH-1:0] in_bit_3,
    input  logic [OB_BITSTREAM_WIDTH-1:0] in_last_bit,
    input  logic                          in_flag_last,
    input  logic                          out_ready,
    output logic                          in_ready,
    output logic [OB_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [OB_ADDR_WIDTH:0]        out_count,
    output logic                          out_error
);

    localparam int unsigned Depth = 2 ** OB_ADDR_WIDTH;
    localparam int unsigned CntW  = OB_ADDR_WIDTH + 1;

    typedef logic [OB_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CntW-1:0]          cnt_t;

    logic [OB_BITSTREAM_WIDTH-1:0] mem [Depth];
    logic [Depth-1:0]              tag;
    ptr_t                          rd_ptr;
    ptr_t                          wr_ptr;
    cnt_t                          count;
    logic                          error;

    logic                          flag_legal;
    logic                          push;
    logic                          pop;
    cnt_t                          n;
    logic [OB_BITSTREAM_WIDTH-1:0] grp [4];

    always_comb begin
        grp[0]     = in_bit_1;
        grp[1]     = in_bit_2;
        grp[2]     = in_bit_3;
        grp[3]     = in_last_bit;
        flag_legal = (in_flag_bitstream != 3'd0) && (in_flag_bitstream <= 3'd4);
        push       = flag_legal && in_ready;
        n          = push ? cnt_t'(in_flag_bitstream) : '0;
        pop        = out_valid && out_ready;
    end

    // Room for a worst-case group of four is required before any group is taken.
    assign in_ready  = (count <= cnt_t'(Depth - 4));
    assign out_valid = (count != '0);
    assign out_byte  = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid & tag[rd_ptr];
    assign out_count = count;
    assign out_error = error;

    // Data storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge ob_clk) begin
        if (ob_reset && push) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(in_flag_bitstream)) begin
                    mem[wr_ptr + ptr_t'(i)] <= grp[i];
                end
            end
        end
    end

    always_ff @(posedge ob_clk) begin
        if (!ob_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            tag    <= '0;
            error  <= 1'b0;
        end else begin
            if (push) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(in_flag_bitstream)) begin
                        tag[wr_ptr + ptr_t'(i)] <= in_flag_last &&
                                                   (i == int'(in_flag_bitstream) - 1);
                    end
                end
                wr_ptr <= wr_ptr + ptr_t'(in_flag_bitstream);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count <= count + n - cnt_t'(pop);
            // Covers both overflow of a legal group and illegal flag codes.
            if ((in_flag_bitstream != 3'd0) && !push) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_output_buffer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_bitstream_output_buffer;

    logic       ob_clk = 1'b0;
    logic       ob_reset;
    logic [2:0] in_flag_bitstream;
    logic [7:0] in_bit_1, in_bit_2, in_bit_3, in_last_bit;
    logic       in_flag_last;
    logic       out_ready;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_last;
    logic [4:0] out_count;
    logic       out_error;

    int checks   = 0;
    int failures = 0;

    bitstream_output_buffer #(
        .OB_BITSTREAM_WIDTH(8),
        .OB_ADDR_WIDTH     (4)
    ) dut (
        .ob_clk           (ob_clk),
        .ob_reset         (ob_reset),
        .in_flag_bitstream(in_flag_bitstream),
        .in_bit_1         (in_bit_1),
        .in_bit_2         (in_bit_2),
        .in_bit_3         (in_bit_3),
        .in_last_bit      (in_last_bit),
        .in_flag_last     (in_flag_last),
        .out_ready        (out_ready),
        .in_ready         (in_ready),
        .out_byte         (out_byte),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_count        (out_count),
        .out_error        (out_error)
    );

    always #5 ob_clk = ~ob_clk;

    typedef struct {
        logic [2:0] flag;
        logic [7:0] b1, b2, b3, bl;
        logic       last;
        logic       ready;
        logic       e_valid;
        logic [7:0] e_byte;
        logic       e_last;
        logic [4:0] e_count;
        logic       e_err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ob_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic l,
                         input logic r);
        in_flag_bitstream = f;
        in_bit_1          = a;
        in_bit_2          = b;
        in_bit_3          = c;
        in_last_bit       = d;
        in_flag_last      = l;
        out_ready         = r;
    endtask

    task automatic idle(input logic r);
        drive(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, r);
    endtask

    task automatic do_reset();
        idle(1'b0);
        ob_reset = 1'b0;
        tick();
        ob_reset = 1'b1;
    endtask

    logic [8:0] q [$];
    logic       m_err;
    int         groups;
    logic       exp_ready;
    logic [2:0] f;
    logic [7:0] rb [4];
    logic       rl, rr;

    initial begin
        ob_reset = 1'b0;
        idle(1'b0);
        tick();
        tick();
        ob_reset = 1'b1;

        chk("rst_valid", out_valid, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_last", out_last, 0);
        chk("rst_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_error", out_error, 0);

        // Basic push, last marker, ignored last with flag 0, illegal flag.
        vecs[0]  = '{3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 5'd3, 1'b0};
        vecs[1]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0};
        vecs[2]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 5'd1, 1'b0};
        vecs[3]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
        vecs[4]  = '{3'd4, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 5'd4, 1'b0};
        vecs[5]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 5'd3, 1'b0};
        vecs[6]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 5'd2, 1'b0};
        vecs[7]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 5'd1, 1'b0};
        vecs[8]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
        vecs[9]  = '{3'd0, 8'h99, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
        vecs[10] = '{3'd5, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].flag, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].bl,
                  vecs[i].last, vecs[i].ready);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_byte", i), out_byte, vecs[i].e_byte);
            chk($sformatf("vec%0d_last", i), out_last, vecs[i].e_last);
            chk($sformatf("vec%0d_count", i), out_count, vecs[i].e_count);
            chk($sformatf("vec%0d_error", i), out_error, vecs[i].e_err);
        end

        // Backpressure to full, overflow, then in-order drain.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full_in_ready_%0d", k), in_ready, 1);
            drive(3'd4, 8'(8'h40 + 4 * k), 8'(8'h41 + 4 * k), 8'(8'h42 + 4 * k),
                  8'(8'h43 + 4 * k), 1'b0, 1'b0);
            tick();
        end
        chk("full_count", out_count, 16);
        chk("full_in_ready", in_ready, 0);
        chk("full_no_err", out_error, 0);
        drive(3'd4, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b0);
        tick();
        chk("ovf_count", out_count, 16);
        chk("ovf_error", out_error, 1);
        idle(1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_byte_%0d", i), out_byte, 8'(8'h40 + i));
            chk($sformatf("drain_last_%0d", i), out_last, 0);
            tick();
        end
        chk("drain_valid", out_valid, 0);
        chk("drain_error_sticky", out_error, 1);

        // in_ready threshold between 12 and 13 entries.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(3'd4, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
            tick();
        end
        chk("thr12_in_ready", in_ready, 1);
        drive(3'd1, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("thr13_count", out_count, 13);
        chk("thr13_in_ready", in_ready, 0);
        idle(1'b1);
        tick();
        chk("thr12b_in_ready", in_ready, 1);

        // Simultaneous push and pop at count 1.
        do_reset();
        drive(3'd1, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("pp_pre_byte", out_byte, 8'h77);
        drive(3'd2, 8'h88, 8'h99, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        chk("pp_count", out_count, 2);
        chk("pp_head", out_byte, 8'h88);
        idle(1'b1);
        tick();
        chk("pp_head2", out_byte, 8'h99);
        chk("pp_count2", out_count, 1);

        // Reset mid-frame discards buffer and clears the error flag.
        do_reset();
        drive(3'd4, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0, 1'b0);
        tick();
        drive(3'd2, 8'hC4, 8'hC5, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        drive(3'd6, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("mid_count6", out_count, 6);
        chk("mid_err_pre", out_error, 1);
        drive(3'd3, 8'hD0, 8'hD1, 8'hD2, 8'h00, 1'b1, 1'b1);
        ob_reset = 1'b0;
        tick();
        ob_reset = 1'b1;
        chk("mid_valid", out_valid, 0);
        chk("mid_count", out_count, 0);
        chk("mid_error", out_error, 0);
        chk("mid_last", out_last, 0);
        drive(3'd1, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("mid_new_byte", out_byte, 8'h55);
        chk("mid_new_count", out_count, 1);

        // Randomized run across pointer wrap against a queue model.
        do_reset();
        q.delete();
        m_err  = 1'b0;
        groups = 0;
        for (int cyc = 0; cyc < 3000 && groups < 40; cyc++) begin
            f  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
            rr = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < 4; j++) rb[j] = 8'($urandom);
            exp_ready = (16 - q.size()) >= 4;
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_valid", out_valid, q.size() != 0);
            chk("rnd_byte", out_byte, (q.size() != 0) ? q[0][7:0] : 8'h00);
            chk("rnd_last", out_last, (q.size() != 0) ? q[0][8] : 1'b0);
            drive(f, rb[0], rb[1], rb[2], rb[3], rl, rr);
            tick();
            if (rr && q.size() != 0) void'(q.pop_front());
            if (f != 3'd0) begin
                if (exp_ready) begin
                    for (int j = 0; j < int'(f); j++) q.push_back({rl && (j == int'(f) - 1), rb[j]});
                    groups++;
                end else begin
                    m_err = 1'b1;
                end
            end
            chk("rnd_count", out_count, q.size());
            chk("rnd_count_max", out_count <= 5'd16, 1);
            chk("rnd_error", out_error, m_err);
        end
        chk("rnd_groups", groups, 40);
        idle(1'b1);
        for (int i = 0; i < 24; i++) begin
            if (q.size() == 0) break;
            chk("rnd_drain_byte", out_byte, q[0][7:0]);
            chk("rnd_drain_last", out_last, q[0][8]);
            tick();
            void'(q.pop_front());
        end
        chk("rnd_drain_empty", out_valid, 0);
        chk("rnd_drain_count", out_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_output_buffer.md
BITSTREAM_OUTPUT_BUFFER -- requirements
Module: bitstream_output_buffer

Interface
REQ-001 SHALL have parameter OB_BITSTREAM_WIDTH, default 8: width of one bitstream byte.
REQ-002 SHALL have parameter OB_ADDR_WIDTH, default 4: FIFO address width, so depth is 2**OB_ADDR_WIDTH (16).
REQ-003 SHALL have port ob_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ob_reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_flag_bitstream, input, 3 bits: number of valid bytes this cycle. 0 = none, 1 = bit_1, 2 = bit_1..2, 3 = bit_1..3, 4 = bit_1..3 + last_bit.
REQ-006 SHALL have ports in_bit_1, in_bit_2, in_bit_3 and in_last_bit, input, OB_BITSTREAM_WIDTH each: carry-resolved bytes, in stream order.
REQ-007 SHALL have port in_flag_last, input, 1 bit: the group presented this cycle ends the frame.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_byte this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: at least 4 free entries.
REQ-010 SHALL have port out_byte, output, OB_BITSTREAM_WIDTH: head-of-FIFO byte.
REQ-011 SHALL have port out_valid, output, 1 bit: out_byte holds valid data.
REQ-012 SHALL have port out_last, output, 1 bit: out_byte is the final byte of a frame.
REQ-013 SHALL have port out_count, output, OB_ADDR_WIDTH+1 bits: current occupancy.
REQ-014 SHALL have port out_error, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL implement a circular FIFO using rd_ptr, wr_ptr (OB_ADDR_WIDTH bits, wrapping 15 -> 0) and count (0..16), with one tag bit per entry holding the last marker.
REQ-016 SHALL write a group, when in_flag_bitstream is 1..4 and in_ready is 1, by storing n bytes in the order bit_1, bit_2, bit_3, last_bit at wr_ptr..wr_ptr+n-1 (mod depth). wr_ptr then advances by n.
REQ-017 SHALL set the tag of the highest written entry when in_flag_last is 1; all other written entries SHALL get tag 0.
REQ-018 SHALL drive in_ready combinationally as (16 - count) >= 4.
REQ-019 SHALL treat a group with in_flag_bitstream 1..4 while in_ready = 0 as an overflow: the whole group is dropped, no partial write, and out_error is set.
REQ-020 SHALL treat in_flag_bitstream values 5..7 as illegal: nothing is written and out_error is set.
REQ-021 SHALL ignore in_flag_last when in_flag_bitstream = 0 (no write, no error).
REQ-022 SHALL drive out_valid = (count != 0), out_byte = mem[rd_ptr] and out_last = tag[rd_ptr], all combinationally. out_byte and out_last SHALL be zero whenever out_valid = 0.
REQ-023 SHALL pop only when out_valid and out_ready are both 1: rd_ptr advances by 1 and count decrements.
REQ-024 SHALL handle a push and a pop in the same cycle as count_next = count + n - 1. The pop SHALL read the pre-edge head.
REQ-025 SHALL have a latency of one edge: a byte written on edge k is visible on out_byte after edge k, provided it is at the head.
REQ-026 SHALL hold out_byte and out_last stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL never change byte order: bytes leave in exactly the order they were written across groups.
REQ-028 SHALL hold out_error at 1 until reset.

Reset
REQ-029 SHALL, when ob_reset = 0 at a rising edge, clear rd_ptr, wr_ptr, count, all tags and out_error. Memory data contents need not be cleared.
REQ-030 SHALL have these outputs immediately after reset: out_valid = 0, out_byte = 0, out_last = 0, out_count = 0, in_ready = 1, out_error = 0.
REQ-031 SHALL let reset take priority over any simultaneous push or pop. A reset in the middle of a frame discards all buffered bytes, and no out_last is emitted for the discarded frame.

Verification
REQ-032 SHALL be verified with a basic push: flag = 3, bytes 0x11/0x22/0x33, out_ready = 1 -> out_byte is 0x11, 0x22, 0x33 on consecutive cycles, then out_valid = 0.
REQ-033 SHALL be verified with a last marker: flag = 4, bytes 0xA0..0xA3, in_flag_last = 1 -> out_last = 1 only while out_byte = 0xA3.
REQ-034 SHALL be verified with backpressure and full: out_ready = 0 and four flag = 4 pushes -> count = 16, in_ready deasserts at count 13; a fifth push leaves count at 16 and sets out_error = 1; all 16 bytes drain in order.
REQ-035 SHALL be verified with simultaneous push and pop at count = 1: flag = 2 with out_ready = 1 -> count = 2 after the edge, head advances correctly.
REQ-036 SHALL be verified across pointer wrap: 40 random groups (flag 1..4) with random out_ready -> the output sequence equals the input sequence byte for byte, and count never exceeds 16.
REQ-037 SHALL be verified with reset mid-frame: 6 bytes buffered, ob_reset = 0 for one edge -> out_valid = 0, count = 0, out_error = 0; a new push of 0x55 then emerges first.
